// File: rtl/writeback_vrf_v_if.sv
// Writeback / decode bundle for the vector register file: MEM/WB inputs,
// combinational read ports, issue request and the hazard stall.
interface writeback_vrf_v_if #(
    parameter int NREG = 8,
    parameter int VW   = 256,
    parameter int AW   = 3
);
    logic            RegWriteW;
    logic            MemtoRegW;
    logic [VW-1:0]   ReadDataW;
    logic [VW-1:0]   ALUOutW;
    logic [AW-1:0]   WA3W;
    logic [VW-1:0]   ResultW;
    logic [AW-1:0]   RA1D;
    logic [AW-1:0]   RA2D;
    logic [VW-1:0]   RD1D;
    logic [VW-1:0]   RD2D;
    logic            IssueValidD;
    logic            IssueRegWriteD;
    logic [AW-1:0]   IssueWA3D;
    logic            StallD;
    logic [NREG-1:0] PendingV;

    // Pipeline side: drives writeback and decode requests.
    modport master (
        output RegWriteW, MemtoRegW, ReadDataW, ALUOutW, WA3W,
        output RA1D, RA2D, IssueValidD, IssueRegWriteD, IssueWA3D,
        input  ResultW, RD1D, RD2D, StallD, PendingV
    );

    // Register file side.
    modport slave (
        input  RegWriteW, MemtoRegW, ReadDataW, ALUOutW, WA3W,
        input  RA1D, RA2D, IssueValidD, IssueRegWriteD, IssueWA3D,
        output ResultW, RD1D, RD2D, StallD, PendingV
    );
endinterface

// File: rtl/writeback_vrf_v.sv
// Vector writeback stage, NREG x VW register file with two read ports and a
// pending-write scoreboard. Define VRF_BYPASS_EN for write-first read bypass.
module writeback_vrf_v #(
    parameter int NREG = 8,
    parameter int VW   = 256,
    parameter int AW   = 3
) (
    input logic             clk,
    input logic             rst,
    writeback_vrf_v_if.slave bus
);

    logic [VW-1:0]   result;
    logic [VW-1:0]   vrf_q [NREG];
    logic [NREG-1:0] pending_q;
    logic [NREG-1:0] pending_d;
    logic            hit1;
    logic            hit2;
    logic            hz1;
    logic            hz2;
    logic            stall;

    assign result      = bus.MemtoRegW ? bus.ReadDataW : bus.ALUOutW;
    assign bus.ResultW = result;

    // NOTE: the array is flop-based and fully reset, so decode can read any
    // register straight out of reset; a memory macro could not offer that.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) begin
                vrf_q[r] <= '0;
            end
        end else if (bus.RegWriteW) begin
            // NOTE: non-blocking so every reader this cycle sees pre-edge state.
            vrf_q[bus.WA3W] <= result;
        end
    end

`ifdef VRF_BYPASS_EN
    assign hit1     = bus.RegWriteW && (bus.WA3W == bus.RA1D);
    assign hit2     = bus.RegWriteW && (bus.WA3W == bus.RA2D);
    assign bus.RD1D = hit1 ? result : vrf_q[bus.RA1D];
    assign bus.RD2D = hit2 ? result : vrf_q[bus.RA2D];
`else
    assign hit1     = 1'b0;
    assign hit2     = 1'b0;
    assign bus.RD1D = vrf_q[bus.RA1D];
    assign bus.RD2D = vrf_q[bus.RA2D];
`endif

    // Conservative: both sources are checked whether or not the op uses them.
    assign hz1        = pending_q[bus.RA1D] & ~hit1;
    assign hz2        = pending_q[bus.RA2D] & ~hit2;
    assign stall      = bus.IssueValidD & (hz1 | hz2);
    assign bus.StallD = stall;

    always_comb begin
        // NOTE: start from the held value so no path leaves pending_d unassigned.
        pending_d = pending_q;
        if (bus.RegWriteW) begin
            pending_d[bus.WA3W] = 1'b0;
        end
        // Applied after the clear so a newer in-flight writer keeps the bit set.
        if (bus.IssueValidD && bus.IssueRegWriteD && !stall) begin
            pending_d[bus.IssueWA3D] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign bus.PendingV = pending_q;

endmodule

// File: tb/tb_writeback_vrf_v.sv
// Self-checking bench for writeback_vrf_v: reset, writeback mux table, hazard
// stall (bypass-aware), set/clear collision and stalled-issue sequences.
module tb_writeback_vrf_v;
    localparam int NREG = 8;
    localparam int VW   = 256;
    localparam int AW   = 3;

    typedef logic [VW-1:0] vec_t;

    typedef struct {
        logic          m2r;
        vec_t          rdata;
        vec_t          alu;
        logic [AW-1:0] wa;
        vec_t          exp;
    } wb_vec_t;

    typedef struct {
        logic [AW-1:0] addr;
        vec_t          data;
    } sb_entry_t;

    logic      clk = 1'b0;
    logic      rst = 1'b1;
    int        errors = 0;
    int        checks = 0;
    sb_entry_t sb_q[$];
    wb_vec_t   tbl[8];

    writeback_vrf_v_if #(.NREG(NREG), .VW(VW), .AW(AW)) bus ();

    writeback_vrf_v #(.NREG(NREG), .VW(VW), .AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input vec_t act, input vec_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        bus.RegWriteW      = 1'b0;
        bus.MemtoRegW      = 1'b0;
        bus.ReadDataW      = '0;
        bus.ALUOutW        = '0;
        bus.WA3W           = '0;
        bus.RA1D           = '0;
        bus.RA2D           = '0;
        bus.IssueValidD    = 1'b0;
        bus.IssueRegWriteD = 1'b0;
        bus.IssueWA3D      = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_wb(input logic m2r, input vec_t rdata, input vec_t alu,
                            input logic [AW-1:0] wa);
        bus.RegWriteW = 1'b1;
        bus.MemtoRegW = m2r;
        bus.ReadDataW = rdata;
        bus.ALUOutW   = alu;
        bus.WA3W      = wa;
    endtask

    task automatic issue(input logic [AW-1:0] wa, input logic [AW-1:0] ra1,
                         input logic [AW-1:0] ra2);
        bus.IssueValidD    = 1'b1;
        bus.IssueRegWriteD = 1'b1;
        bus.IssueWA3D      = wa;
        bus.RA1D           = ra1;
        bus.RA2D           = ra2;
    endtask

    function automatic wb_vec_t mk(input logic m2r, input vec_t rdata, input vec_t alu,
                                   input logic [AW-1:0] wa, input vec_t exp);
        wb_vec_t v;
        v.m2r   = m2r;
        v.rdata = rdata;
        v.alu   = alu;
        v.wa    = wa;
        v.exp   = exp;
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t      ones;
        vec_t      a5;
        vec_t      v2_old;
        vec_t      wb_val;
        sb_entry_t e;

        ones   = '1;
        a5     = {32{8'hA5}};
        v2_old = {4{64'h0123_4567_89AB_CDEF}};
        wb_val = {8{32'h600D_F00D}};

        tbl[0] = mk(1'b1, 256'h1, 256'h2, 3'd6, 256'h1);
        tbl[1] = mk(1'b0, {8{32'h1111_1111}}, {8{32'hDEAD_BEEF}}, 3'd1, {8{32'hDEAD_BEEF}});
        tbl[2] = mk(1'b1, v2_old, ones, 3'd2, v2_old);
        tbl[3] = mk(1'b0, ones, {16{16'h5A5A}}, 3'd3, {16{16'h5A5A}});
        tbl[4] = mk(1'b1, {1'b1, 255'b0}, '0, 3'd4, {1'b1, 255'b0});
        tbl[5] = mk(1'b0, '0, 256'hCAFE, 3'd5, 256'hCAFE);
        tbl[6] = mk(1'b0, '0, 256'hFF, 3'd0, 256'hFF);
        tbl[7] = mk(1'b1, ones, '0, 3'd7, ones);

        // Out of reset: empty file, no pending writes.
        idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        bus.RA1D = 3'd3;
        #1;
        check("reset_rd1", bus.RD1D, '0);
        check("reset_pending", vec_t'(bus.PendingV), '0);
        check("reset_stall", vec_t'(bus.StallD), '0);

        // Load v3, issue to v5, then assert reset mid-cycle.
        drive_wb(1'b0, '0, a5, 3'd3);
        tick();
        bus.RegWriteW = 1'b0;
        issue(3'd5, 3'd3, 3'd3);
        tick();
        idle();
        bus.RA1D = 3'd3;
        #1;
        check("pre_reset_v3", bus.RD1D, a5);
        check("pre_reset_pending", vec_t'(bus.PendingV), vec_t'(8'h20));
        rst = 1'b1;
        issue(3'd5, 3'd5, 3'd3);
        drive_wb(1'b0, '0, a5, 3'd3);
        #1;
        check("rst_async_rd2", bus.RD2D, '0);
        check("rst_async_pending", vec_t'(bus.PendingV), '0);
        check("rst_async_stall", vec_t'(bus.StallD), '0);
        tick();
        tick();
        check("rst_held_rd2", bus.RD2D, '0);
        check("rst_held_pending", vec_t'(bus.PendingV), '0);
        idle();
        rst = 1'b0;
        tick();

        // Writeback mux table, back-to-back writes to distinct registers.
        for (int i = 0; i < 8; i++) begin
            drive_wb(tbl[i].m2r, tbl[i].rdata, tbl[i].alu, tbl[i].wa);
            if (i > 0) bus.RA2D = tbl[i-1].wa;
            #1;
            check($sformatf("result_%0d", i), bus.ResultW, tbl[i].exp);
            if (i > 0) check($sformatf("next_cycle_rd2_%0d", i), bus.RD2D, tbl[i-1].exp);
            sb_q.push_back('{addr: tbl[i].wa, data: tbl[i].exp});
            tick();
        end
        bus.RegWriteW = 1'b0;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            bus.RA1D = e.addr;
            bus.RA2D = e.addr;
            #1;
            check($sformatf("readback_rd1_v%0d", e.addr), bus.RD1D, e.data);
            check($sformatf("readback_rd2_v%0d", e.addr), bus.RD2D, e.data);
        end
        check("table_pending", vec_t'(bus.PendingV), '0);
        tick();

        // RAW hazard: producer to v2, dependent reads v2 and wants v7.
        issue(3'd2, 3'd0, 3'd1);
        #1;
        check("haz_producer_nostall", vec_t'(bus.StallD), '0);
        tick();
        issue(3'd7, 3'd2, 3'd0);
        #1;
        check("haz_pending_v2", vec_t'(bus.PendingV), vec_t'(8'h04));
        check("haz_stall_c1", vec_t'(bus.StallD), vec_t'(1'b1));
        tick();
        check("haz_stall_c2", vec_t'(bus.StallD), vec_t'(1'b1));
        check("stalled_issue_no_set", vec_t'(bus.PendingV), vec_t'(8'h04));
        tick();
        drive_wb(1'b0, '0, wb_val, 3'd2);
        sb_q.push_back('{addr: 3'd2, data: wb_val});
        #1;
        check("haz_wb_result", bus.ResultW, wb_val);
`ifdef VRF_BYPASS_EN
        check("haz_wb_stall_bypass", vec_t'(bus.StallD), '0);
        e = sb_q.pop_front();
        check("haz_wb_rd1_bypass", bus.RD1D, e.data);
        tick();
        idle();
        #1;
        check("haz_pending_after", vec_t'(bus.PendingV), vec_t'(8'h80));
`else
        check("haz_wb_stall_nobypass", vec_t'(bus.StallD), vec_t'(1'b1));
        check("haz_wb_rd1_old", bus.RD1D, v2_old);
        tick();
        bus.RegWriteW = 1'b0;
        #1;
        check("haz_release_stall", vec_t'(bus.StallD), '0);
        e = sb_q.pop_front();
        check("haz_release_rd1", bus.RD1D, e.data);
        check("haz_pending_cleared", vec_t'(bus.PendingV), '0);
        tick();
        idle();
        #1;
        check("haz_pending_after", vec_t'(bus.PendingV), vec_t'(8'h80));
`endif
        drive_wb(1'b0, '0, '0, 3'd7);
        tick();
        idle();
        #1;
        check("retire_v7_pending", vec_t'(bus.PendingV), '0);

        // Issue without register write sets nothing.
        bus.IssueValidD = 1'b1;
        bus.IssueWA3D   = 3'd3;
        tick();
        idle();
        check("no_regwrite_no_set", vec_t'(bus.PendingV), '0);

        // Set/clear collision on v4, also a WAW issue that must not stall.
        issue(3'd4, 3'd0, 3'd1);
        tick();
        check("coll_pending_set", vec_t'(bus.PendingV), vec_t'(8'h10));
        drive_wb(1'b0, '0, 256'h4, 3'd4);
        #1;
        check("waw_no_stall", vec_t'(bus.StallD), '0);
        tick();
        idle();
        #1;
        check("coll_set_wins", vec_t'(bus.PendingV), vec_t'(8'h10));
        drive_wb(1'b0, '0, 256'h44, 3'd4);
        tick();
        idle();
        bus.RA1D = 3'd4;
        #1;
        check("coll_final_clear", vec_t'(bus.PendingV), '0);
        check("coll_final_v4", bus.RD1D, 256'h44);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/writeback_vrf_v.md
# writeback_vrf_v

Vector writeback stage and register file for the SIMD pipeline. Sits directly downstream of the memory stage and consumes its MEM/WB outputs: RegWriteW, MemtoRegW, ReadDataW, ALUOutW and WA3W. Selects the writeback result, commits it to an 8 × 256-bit vector register file, and serves two combinational read ports to decode. A pending-write scoreboard stalls decode on read-after-write hazards.

## Interface

Parameters:
- NREG, 8, number of vector registers.
- VW, 256, vector width in bits.
- AW, 3, register address width; must satisfy 2**AW == NREG.

Ports (clock and reset first):
- clk  in  1  single pipeline clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- RegWriteW  in  1  writeback enable from the MEM/WB register.
- MemtoRegW  in  1  1 selects ReadDataW as result, 0 selects ALUOutW.
- ReadDataW  in  VW  memory read data.
- ALUOutW  in  VW  ALU result.
- WA3W  in  AW  destination register.
- ResultW  out  VW  selected writeback value, combinational.
- RA1D, RA2D  in  AW  decode source addresses.
- RD1D, RD2D  out  VW  decode read data, combinational.
- IssueValidD  in  1  decode issues an instruction this cycle.
- IssueRegWriteD  in  1  the issued instruction writes a register.
- IssueWA3D  in  AW  destination of the issued instruction.
- StallD  out  1  hazard stall to decode and fetch.
- PendingV  out  NREG  scoreboard bits, for debug.

## Operation

- ResultW = MemtoRegW ? ReadDataW : ALUOutW.
- Write: on posedge, if RegWriteW, then vrf[WA3W] <= ResultW. All registers are writable; there is no hard-wired zero register.
- Read: RDxD = vrf[RAxD], subject to the bypass rule in Configuration.
- Scoreboard, per register r:
  - Set: IssueValidD & IssueRegWriteD & ~StallD & IssueWA3D == r.
  - Clear: RegWriteW & WA3W == r.
  - Set and clear on the same r in the same cycle: set wins. A newer writer is in flight.
  - Set is suppressed while StallD = 1. Decode must hold its instruction.
- Hazard, for port x: hzx = pending[RAxD] & ~bypass_hit_x, where bypass_hit_x = BYPASS compiled in & RegWriteW & WA3W == RAxD.
- StallD = IssueValidD & (hz1 | hz2), combinational. The stall does not depend on whether the source operand is actually used.
- A WAW case (destination already pending) does not stall: in-order retirement keeps it safe, and the pending bit stays set until the later writer retires.

## Timing

- Reset (async assert, release synchronous to clk): every vrf entry = 0, PendingV = 0. While rst = 1, writes and scoreboard sets are blocked.
- Reset asserted mid-operation: in-flight writes are lost and PendingV clears immediately. Upstream stages are reset by the same signal.
- Write latency: data written at edge N is readable through the array from cycle N+1.
- ResultW, RD1D, RD2D and StallD are purely combinational from their inputs and current state.
- Scoreboard set at edge N is visible in PendingV from cycle N+1.
- Minimum stall for a dependent instruction issued back-to-back behind a producer, with 3 stages between issue and writeback:
  - With bypass: 2 stall cycles.
  - Without bypass: 3 stall cycles.

## Configuration

- Macro: VRF_BYPASS_EN.
- Defined: write-first bypass. If RegWriteW and WA3W == RAxD, RDxD = ResultW in the same cycle, and the hazard on that port is cancelled.
- Undefined: RDxD always comes from the array. A matching writeback lands at the edge, and StallD stays high for that cycle. No bypass mux is generated.

## Test plan

- Reset: hold rst = 1 after writing 0xA5…A5 to v3 and issuing to v5 → RD1D(RA1D=3) = 0, PendingV = 8'h00, StallD = 0.
- Writeback mux: MemtoRegW = 1, ReadDataW = 256'h1, ALUOutW = 256'h2, WA3W = 6, RegWriteW = 1 → ResultW = 256'h1. Next cycle, RD2D(RA2D=6) = 256'h1.
- Hazard: issue with IssueWA3D = 2 → PendingV[2] = 1. Issue with RA1D = 2 → StallD = 1 until the writeback to v2.
  - Bypass defined: StallD = 0 in the writeback cycle and RD1D = ResultW.
  - Bypass undefined: StallD = 1 in the writeback cycle and 0 the next cycle.
- Set/clear collision: RegWriteW with WA3W = 4 and an issue to 4 in the same cycle → PendingV[4] stays 1.
- Stalled issue: StallD = 1 while IssueWA3D = 7 → PendingV[7] remains 0.
- Back-to-back writes: v0 and v7 written with 256'hFF and all-ones on consecutive cycles → both read back correctly, and the other 6 registers are unchanged.
